// File: rtl/osc_net_pkg.sv
// Shared types and helpers for the lateral inhibition controller.
package osc_net_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INHIBIT = 2'd1,
    HOLDOFF = 2'd2
  } li_state_e;

  // Width of an index into n entries (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_arbiter.sv
// Combinational winner select over a vector of spike rises.
// Default: lowest set index wins.
// ROUND_ROBIN_EN: search starts at rr_ptr, ascending with wrap.
module spike_arbiter
  import osc_net_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         rise_vec,
  input  logic [idx_w(N)-1:0]  rr_ptr,
  output logic [idx_w(N)-1:0]  grant_idx,
  output logic                 grant_any
);

  localparam int IW = idx_w(N);

`ifdef ROUND_ROBIN_EN
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;

  // rotate so rr_ptr lands at bit 0, take lowest set bit, then undo the rotation mod N
  always_comb begin
    dbl       = {rise_vec, rise_vec} >> rr_ptr;
    rot       = dbl[N-1:0];
    sum       = '0;
    grant_idx = '0;
    grant_any = |rise_vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) sum = {1'b0, IW'(i)} + {1'b0, rr_ptr};
    end
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    grant_idx = sum[IW-1:0];
  end
`else
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

  // fixed priority: scan downward so the lowest set index is written last
  always_comb begin
    grant_idx = '0;
    grant_any = |rise_vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (rise_vec[i]) grant_idx = IW'(i);
    end
  end
`endif

endmodule

// File: rtl/lateral_inhibit_ctrl.sv
// Winner-take-all lateral inhibition for N spiking neurons.
// Edge-detects spikes, picks one winner per event, inhibits the losers for
// INH_LEN cycles, then ignores spikes for HOLD_LEN cycles. Keeps saturating
// per-neuron win counters for readout.
// Optional macro ROUND_ROBIN_EN selects rotating-priority arbitration.
module lateral_inhibit_ctrl
  import osc_net_pkg::*;
#(
  parameter int N        = 4,
  parameter int INH_LEN  = 3,
  parameter int HOLD_LEN = 2,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N-1:0]         spike_in,
  input  logic                 cnt_clr,
  input  logic [idx_w(N)-1:0]  cnt_sel,
  output logic [N-1:0]         inhibit_out,
  output logic [idx_w(N)-1:0]  winner_idx,
  output logic                 winner_valid,
  output logic [CNT_W-1:0]     win_cnt_out
);

  localparam int IW        = idx_w(N);
  localparam int PMAX      = (INH_LEN > HOLD_LEN) ? INH_LEN : HOLD_LEN;
  localparam int PW        = $clog2(PMAX + 1);
  localparam int HOLD_M1   = (HOLD_LEN > 0) ? HOLD_LEN - 1 : 0;
  localparam logic [PW-1:0] INH_INIT  = PW'(INH_LEN - 1);
  localparam logic [PW-1:0] HOLD_INIT = PW'(HOLD_M1);

  logic [N-1:0]             spike_q, spike_q2, rise;
  li_state_e                state, state_n;
  logic [PW-1:0]            phase, phase_n;
  logic [N-1:0]             inh_n;
  logic [IW-1:0]            widx_n;
  logic                     wvld_n;
  logic                     sel;
  logic [IW-1:0]            grant_idx, rr_ptr;
  logic                     grant_any;
  logic [N-1:0][CNT_W-1:0]  win_cnt;

  assign rise = spike_q & ~spike_q2;

  spike_arbiter #(.N(N)) u_arb (
    .rise_vec  (rise),
    .rr_ptr    (rr_ptr),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // next-state and next-output decode; rises outside IDLE are simply dropped
  always_comb begin
    state_n = state;
    phase_n = phase;
    inh_n   = inhibit_out;
    widx_n  = winner_idx;
    wvld_n  = 1'b0;
    sel     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          sel     = 1'b1;
          widx_n  = grant_idx;
          wvld_n  = 1'b1;
          inh_n   = ~(N'(1) << grant_idx);
          phase_n = INH_INIT;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (phase == '0) begin
          inh_n = '0;
          if (HOLD_LEN == 0) begin
            state_n = IDLE;
          end else begin
            state_n = HOLDOFF;
            phase_n = HOLD_INIT;
          end
        end else begin
          phase_n = phase - 1'b1;
        end
      end
      HOLDOFF: begin
        if (phase == '0) state_n = IDLE;
        else             phase_n = phase - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // state, edge-detect and output registers; ena freezes everything but reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_q      <= '0;
      spike_q2     <= '0;
      state        <= IDLE;
      phase        <= '0;
      inhibit_out  <= '0;
      winner_idx   <= '0;
      winner_valid <= 1'b0;
    end else if (ena) begin
      spike_q      <= spike_in;
      spike_q2     <= spike_q;
      state        <= state_n;
      phase        <= phase_n;
      inhibit_out  <= inh_n;
      winner_idx   <= widx_n;
      winner_valid <= wvld_n;
    end
  end

`ifdef ROUND_ROBIN_EN
  // rotate priority to just past the last winner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (ena && sel) begin
      rr_ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  // saturating win counters; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (ena) begin
      if (cnt_clr) begin
        win_cnt <= '0;
      end else if (sel && !(&win_cnt[grant_idx])) begin
        win_cnt[grant_idx] <= win_cnt[grant_idx] + 1'b1;
      end
    end
  end

  assign win_cnt_out = win_cnt[cnt_sel];

endmodule

// File: tb/tb_lateral_inhibit_ctrl.sv
// Self-checking bench for lateral_inhibit_ctrl: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_lateral_inhibit_ctrl;

  localparam int N        = 4;
  localparam int INH_LEN  = 3;
  localparam int HOLD_LEN = 2;
  localparam int CNT_W    = 8;
  localparam int IW       = $clog2(N);
  localparam int CMAX     = (1 << CNT_W) - 1;
  localparam int MASK     = (1 << N) - 1;

  logic             clk = 1'b0;
  logic             rst_n, ena, cnt_clr;
  logic [N-1:0]     spike_in;
  logic [IW-1:0]    cnt_sel;
  logic [N-1:0]     inhibit_out;
  logic [IW-1:0]    winner_idx;
  logic             winner_valid;
  logic [CNT_W-1:0] win_cnt_out;

  int n_tests = 0;
  int n_fail  = 0;

  lateral_inhibit_ctrl #(.N(N), .INH_LEN(INH_LEN), .HOLD_LEN(HOLD_LEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .spike_in     (spike_in),
    .cnt_clr      (cnt_clr),
    .cnt_sel      (cnt_sel),
    .inhibit_out  (inhibit_out),
    .winner_idx   (winner_idx),
    .winner_valid (winner_valid),
    .win_cnt_out  (win_cnt_out)
  );

  always #5 clk = ~clk;

  // model: previous two spike samples, remaining busy / inhibit cycles
  int m_q, m_q2, m_busy, m_inh_left, m_inh, m_widx, m_vld, m_ptr;
  int m_cnt [N];

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_q2 = 0; m_busy = 0; m_inh_left = 0;
    m_inh = 0; m_widx = 0; m_vld = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step();
    int r, w, idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!ena) return;
    r     = m_q & ~m_q2 & MASK;
    m_q2  = m_q;
    m_q   = int'(spike_in);
    m_vld = 0;
    w     = -1;
    if (m_busy == 0 && r != 0) begin
      for (int k = 0; k < N; k++) begin
`ifdef ROUND_ROBIN_EN
        idx = (m_ptr + k) % N;
`else
        idx = k;
`endif
        if (w < 0 && ((r >> idx) & 1) == 1) w = idx;
      end
      m_vld      = 1;
      m_widx     = w;
      m_inh      = MASK & ~(1 << w);
      m_busy     = INH_LEN + HOLD_LEN;
      m_inh_left = INH_LEN;
      m_ptr      = (w + 1) % N;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_inh_left > 0) m_inh_left--;
      if (m_inh_left == 0) m_inh = 0;
    end
    if (cnt_clr) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (w >= 0 && m_cnt[w] < CMAX) begin
      m_cnt[w]++;
    end
  endtask

  task automatic cmp_all();
    chk("inhibit_out", int'(inhibit_out), m_inh);
    chk("winner_idx", int'(winner_idx), m_widx);
    chk("winner_valid", int'(winner_valid), m_vld);
    chk("win_cnt_out", int'(win_cnt_out), m_cnt[cnt_sel]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] seq [6];
    int inh_cyc, vld_cyc;
    model_reset();
    rst_n = 1'b0; ena = 1'b1; cnt_clr = 1'b0; cnt_sel = '0; spike_in = 4'b1111;

    // 1: reset with spikes asserted, then frozen by ena=0
    tick(); tick();
    chk("rst_inhibit", int'(inhibit_out), 0);
    chk("rst_valid", int'(winner_valid), 0);
    rst_n = 1'b1; ena = 1'b0;
    repeat (3) tick();
    chk("ena0_inhibit", int'(inhibit_out), 0);
    chk("ena0_valid", int'(winner_valid), 0);
    spike_in = '0; ena = 1'b1;
    repeat (2) tick();

    // 2: single held spike on neuron 2
    spike_in = 4'b0100;
    tick(); tick();
    chk("single_valid", int'(winner_valid), 1);
    chk("single_idx", int'(winner_idx), 2);
    chk("single_inh", int'(inhibit_out), 4'b1011);
    inh_cyc = 1; vld_cyc = 0;
    repeat (8) begin
      tick();
      if (inhibit_out == 4'b1011) inh_cyc++;
      if (winner_valid) vld_cyc++;
    end
    chk("single_inh_len", inh_cyc, INH_LEN);
    chk("single_vld_once", vld_cyc, 0);
    cnt_sel = 2'd2; #1;
    chk("single_cnt", int'(win_cnt_out), 1);
    spike_in = '0;

    // 3: simultaneous rises on neurons 1 and 2, twice
    do_reset();
    spike_in = 4'b0110;
    tick(); tick();
    chk("simul_idx1", int'(winner_idx), 1);
    spike_in = '0;
    repeat (8) tick();
    spike_in = 4'b0110;
    tick(); tick();
    chk("simul_valid2", int'(winner_valid), 1);
`ifdef ROUND_ROBIN_EN
    chk("simul_idx2", int'(winner_idx), 2);
`else
    chk("simul_idx2", int'(winner_idx), 1);
`endif
    spike_in = '0;

    // 4: rises during INHIBIT and HOLDOFF dropped, first IDLE cycle accepted
    do_reset();
    tick();
    spike_in = 4'b0001;
    tick(); tick();
    chk("block_first", int'(winner_idx), 0);
    seq = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      spike_in = seq[i];
      tick();
      if (i < 5) chk("block_ignored", int'(winner_valid), 0);
    end
    chk("block_accept_vld", int'(winner_valid), 1);
    chk("block_accept_idx", int'(winner_idx), 3);
    spike_in = '0;

    // 5: saturation of neuron 0's counter, then clear against a win
    do_reset();
    cnt_sel = '0;
    tick();
    repeat (260) begin
      spike_in = 4'b0001;
      tick();
      spike_in = '0;
      repeat (7) tick();
    end
    chk("sat_cnt", int'(win_cnt_out), CMAX);
    spike_in = 4'b0001;
    tick();
    cnt_clr = 1'b1;
    tick();
    chk("clr_vs_win_vld", int'(winner_valid), 1);
    chk("clr_vs_win_cnt", int'(win_cnt_out), 0);
    cnt_clr = 1'b0; spike_in = '0;
    repeat (8) tick();

    // 6: reset while inhibiting
    spike_in = 4'b0001;
    tick(); tick();
    chk("midinh_inh", int'(inhibit_out), 4'b1110);
    spike_in = '0;
    rst_n = 1'b0;
    tick();
    chk("midinh_rst_inh", int'(inhibit_out), 0);
    chk("midinh_rst_cnt", int'(win_cnt_out), 0);
    rst_n = 1'b1;

    // randomized traffic against the model
    repeat (1500) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      ena     = ($urandom_range(0, 9) != 0);
      cnt_clr = ($urandom_range(0, 39) == 0);
      cnt_sel = IW'($urandom_range(0, N - 1));
      if ($urandom_range(0, 2) == 0) spike_in = N'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
